// File: rtl/scntru_tmr.sv
// Start/stop timer-counter with one-shot and periodic modes, a registered terminal-count
// pulse and a combinational cascade carry.
module scntru_tmr #(
    parameter int N     = 8,
    parameter     GROUP = "dpath1"   // placement tag only, no functional effect
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         START,
    input  logic         STOP,
    input  logic         MODE,
    input  logic [N-1:0] LIM,
    output logic [N-1:0] Q,
    output logic         TC,
    output logic         BUSY,
    output logic         DONE,
    output logic         COUT
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [N-1:0]   lim_q, lim_d;
    logic           mode_q, mode_d;
    logic           tc_q, tc_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lim_q   <= '0;
            mode_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            mode_q  <= mode_d;
            tc_q    <= tc_d;
        end
    end

    // STOP beats START beats counting; a winning START swallows any terminal event.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        mode_d  = mode_q;
        tc_d    = 1'b0;
        if (STOP) begin
            state_d = StIdle;
        end else if (START) begin
            state_d = StRun;
            cnt_d   = '0;
            lim_d   = LIM;
            mode_d  = MODE;
        end else if (state_q == StRun && EN) begin
            if (cnt_q == lim_q) begin
                tc_d = 1'b1;
                if (mode_q) begin
                    cnt_d = '0;
                end else begin
                    state_d = StFin;
                end
            end else begin
                cnt_d = cnt_q + N'(1);
            end
        end
    end

    assign Q    = cnt_q;
    assign TC   = tc_q;
    assign BUSY = (state_q == StRun);
    assign DONE = (state_q == StFin);
    assign COUT = BUSY & EN & (&cnt_q);

endmodule

// File: tb/tb_scntru_tmr.sv
// Directed, table-driven bench for scntru_tmr (N=8) with hand-written wrap and reset sequences.
module tb_scntru_tmr;

    localparam int N = 8;

    logic         CLK = 1'b0;
    logic         RST, EN, START, STOP, MODE;
    logic [N-1:0] LIM;
    logic [N-1:0] Q;
    logic         TC, BUSY, DONE, COUT;

    int n_checks = 0;
    int n_fail   = 0;

    scntru_tmr #(.N(N), .GROUP("dpath1")) dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .START (START),
        .STOP  (STOP),
        .MODE  (MODE),
        .LIM   (LIM),
        .Q     (Q),
        .TC    (TC),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .COUT  (COUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         rst, en, start, stop, mode;
        logic [N-1:0] lim;
        logic [N-1:0] q;
        logic         tc, busy, done, cout;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic en, input logic start,
                                input logic stop, input logic mode, input int lim,
                                input int q, input logic tc, input logic busy,
                                input logic done, input logic cout);
        vec_t v;
        v.rst = rst; v.en = en; v.start = start; v.stop = stop; v.mode = mode;
        v.lim = N'(lim); v.q = N'(q);
        v.tc = tc; v.busy = busy; v.done = done; v.cout = cout;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic start, input logic stop,
                         input logic mode, input logic [N-1:0] lim);
        @(negedge CLK);
        RST = rst; EN = en; START = start; STOP = stop; MODE = mode; LIM = lim;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input int q, input logic tc, input logic busy,
                             input logic done, input logic cout);
        check({tag, ".Q"}, int'(Q), q);
        check({tag, ".TC"}, int'(TC), int'(tc));
        check({tag, ".BUSY"}, int'(BUSY), int'(busy));
        check({tag, ".DONE"}, int'(DONE), int'(done));
        check({tag, ".COUT"}, int'(COUT), int'(cout));
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; START = 1'b0; STOP = 1'b0; MODE = 1'b0; LIM = '0;

        //  rst en st sp md lim   q  tc bz dn co
        // reset with junk inputs
        add(1, 1, 1, 0, 1, 9,    0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 0);
        // one-shot LIM=5
        add(0, 1, 1, 0, 0, 5,    0, 0, 1, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 0, 0, 0, 5, i, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 5,    5, 1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 5,    5, 0, 0, 1, 0);
        // periodic LIM=2; LIM/MODE changes mid-run ignored
        add(0, 1, 1, 0, 1, 2,    0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 2,    1, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 2,    2, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 2,    0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 7,    1, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 7,    2, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 7,    0, 1, 1, 0, 0);
        // EN gaps, one-shot LIM=3
        add(0, 0, 1, 0, 0, 3,    0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 3,    1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 3,    1, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 3,    2, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 3,    2, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 3,    3, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 3,    3, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 3,    3, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 3,    3, 0, 0, 1, 0);
        // STOP+START at Q=4
        add(0, 1, 1, 0, 0, 9,    0, 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) add(0, 1, 0, 0, 0, 9, i, 0, 1, 0, 0);
        add(0, 1, 1, 1, 0, 9,    4, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 9,    4, 0, 0, 0, 0);
        // START on the terminal edge suppresses TC
        add(0, 1, 1, 0, 1, 1,    0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1,    1, 0, 1, 0, 0);
        add(0, 1, 1, 0, 1, 1,    0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1,    1, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1,    0, 1, 1, 0, 0);
        // RST+START
        add(1, 1, 1, 0, 1, 5,    0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 5,    0, 0, 0, 0, 0);
        // LIM=0 periodic: terminal on every enabled cycle
        add(0, 1, 1, 0, 1, 0,    0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0,    0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0,    0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0,    0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0,    0, 1, 1, 0, 0);
        // STOP from RUN clears BUSY with Q held
        add(0, 1, 0, 1, 1, 0,    0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].start, vecs[i].stop, vecs[i].mode,
                  vecs[i].lim);
            check_all($sformatf("vec%0d", i), int'(vecs[i].q), vecs[i].tc, vecs[i].busy,
                      vecs[i].done, vecs[i].cout);
        end

        // Wrap at 255 in periodic mode with cascade carry.
        drive(0, 1, 1, 0, 1, 8'd255);
        check_all("wrap.start", 0, 0, 1, 0, 0);
        for (int i = 1; i <= 255; i++) begin
            drive(0, 1, 0, 0, 1, 8'd255);
            check($sformatf("wrap%0d.Q", i), int'(Q), i);
            check($sformatf("wrap%0d.COUT", i), int'(COUT), (i == 255) ? 1 : 0);
        end
        EN = 1'b0;
        #1;
        check("wrap.cout_en0", int'(COUT), 0);
        EN = 1'b1;
        #1;
        check("wrap.cout_en1", int'(COUT), 1);
        drive(0, 1, 0, 0, 1, 8'd255);
        check_all("wrap.roll", 0, 1, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 8'd255);
        check_all("wrap.after", 1, 0, 1, 0, 0);

        // Mid-run reset at Q=7 of LIM=20.
        drive(0, 1, 1, 0, 0, 8'd20);
        for (int i = 1; i <= 7; i++) drive(0, 1, 0, 0, 0, 8'd20);
        check_all("mrst.pre", 7, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 8'd20);
        check_all("mrst.rst", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 8'd20);
            check_all($sformatf("mrst.idle%0d", i), 0, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scntru_tmr.md
SCNTRU_TMR -- requirements
Module: scntru_tmr

Interface
REQ-001 SHALL have parameter N, default 8, meaning counter and limit width in bits (2..32).
REQ-002 SHALL have parameter GROUP, default "dpath1", meaning datapath placement group tag with no functional effect.
REQ-003 SHALL have port CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port EN  input  1  count enable; gates counting only, not control.
REQ-006 SHALL have port START  input  1  start or restart request.
REQ-007 SHALL have port STOP  input  1  abort request.
REQ-008 SHALL have port MODE  input  1  0 = one-shot, 1 = periodic; sampled at START.
REQ-009 SHALL have port LIM  input  N  terminal value; sampled at START.
REQ-010 SHALL have port Q  output  N  current count.
REQ-011 SHALL have port TC  output  1  terminal-count pulse, registered.
REQ-012 SHALL have port BUSY  output  1  high in state RUN.
REQ-013 SHALL have port DONE  output  1  high in state FIN.
REQ-014 SHALL have port COUT  output  1  cascade carry, combinational.

Function
REQ-015 SHALL implement three states: IDLE, RUN and FIN; BUSY = (state==RUN), DONE = (state==FIN).
REQ-016 Each-edge priority SHALL be RST > STOP > START > count.
REQ-017 STOP in any state SHALL force IDLE next cycle with Q held and TC=0.
REQ-018 START in any state, absent STOP, SHALL force RUN, Q<=0, and capture LIM into lim_r and MODE into mode_r; a START in RUN SHALL restart the count.
REQ-019 In RUN with EN=1 and Q!=lim_r, Q SHALL become Q+1, modulo 2^N.
REQ-020 In RUN with EN=1 and Q==lim_r, TC SHALL be 1 in the following cycle, and:
  - if mode_r=1, Q SHALL become 0 and the state SHALL stay RUN;
  - if mode_r=0, Q SHALL hold lim_r and the state SHALL go to FIN.
REQ-021 In RUN with EN=0, Q, state and lim_r SHALL hold and TC SHALL be 0.
REQ-022 In IDLE and FIN, Q SHALL hold, EN SHALL be ignored, and TC SHALL be 0 after its single pulse.
REQ-023 TC SHALL be exactly one cycle wide per terminal event; back-to-back pulses are legal when lim_r=0, mode_r=1, EN=1.
REQ-024 With lim_r=0, the first enabled RUN cycle SHALL already be terminal; Q SHALL never exceed lim_r.
REQ-025 COUT SHALL equal BUSY & EN & (Q == all ones), with no registered stage.
REQ-026 Latency: START at edge k SHALL give BUSY=1 and Q=0 after edge k; the first increment SHALL occur at edge k+1 if EN=1.
REQ-027 A START that wins an edge where a terminal event would occur SHALL suppress that TC.
REQ-028 LIM and MODE changes outside START edges SHALL have no effect.

Reset
REQ-029 With RST=1 at an edge: Q=0, TC=0, BUSY=0, DONE=0, state=IDLE, lim_r=0, mode_r=0, regardless of other inputs.
REQ-030 RST mid-RUN SHALL discard the count with no TC; operation SHALL resume only on a later START.
REQ-031 Before the first reset, outputs are undefined; the bench SHALL apply RST for at least 1 cycle.

Verification
REQ-032 One-shot: LIM=5, MODE=0, START pulse, EN=1 -> Q 0,1,2,3,4,5; TC=1 for the one cycle after Q=5 is reached with DONE=1; Q holds 5.
REQ-033 Periodic: LIM=2, MODE=1, EN=1 for 9 cycles -> Q 0,1,2,0,1,2,0,1,2; TC pulses every 3rd cycle; BUSY stays 1.
REQ-034 EN gaps: LIM=3, EN toggling 1,0,1,0... -> Q advances only on EN=1 cycles; TC asserts once, after the 4th enabled cycle.
REQ-035 Collisions:
  - STOP+START same edge at Q=4 -> IDLE, Q=4.
  - START at the terminal edge -> Q=0, no TC.
  - RST+START -> all outputs zero, IDLE.
REQ-036 Wrap and COUT: N=8, LIM=255, MODE=1 -> COUT=1 only while Q=255 with EN=1; the next Q=0 with TC=1; LIM=0 periodic -> TC high every enabled cycle.
REQ-037 Mid-run reset: RST at Q=7 of LIM=20 -> next cycle Q=0, BUSY=0, TC=0, and it stays IDLE with START=0.
